// File: rtl/hc595_shifter.sv
// 74HC595 chain serialiser: captures a word on enable, shifts it out
// MSB first on SER/SRCLK, then pulses RCLK to latch the outputs.
module hc595_shifter #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_enable,
  output logic             o_ready,
  output logic             o_ser,
  output logic             o_srclk,
  output logic             o_rclk,
  output logic             o_oe_n
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CLOCK,
    S_LATCH,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             ready_q, ready_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             oe_n_q, oe_n_d;
  logic             phase_end;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    div_d     = div_q;
    phase_end = (div_q == DIV_LAST);

    if (state_q != S_IDLE) begin
      div_d = phase_end ? '0 : div_q + DW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          shift_d = i_data;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) state_d = S_CLOCK;
      end
      S_CLOCK: begin
        if (phase_end) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q + BW'(1);
          state_d = (bit_q == BIT_LAST) ? S_LATCH : S_SETUP;
        end
      end
      S_LATCH: begin
        if (phase_end) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (phase_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered, so decode them from the next state
    ready_d = (state_d == S_IDLE);
    srclk_d = (state_d == S_CLOCK);
    rclk_d  = (state_d == S_LATCH);
    oe_n_d  = oe_n_q & (state_d != S_FINISH);
    ser_d   = (state_d == S_SETUP) ? shift_d[WIDTH-1] : ser_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      ready_q <= 1'b1;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ready_q <= ready_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign o_ready = ready_q;
  assign o_ser   = ser_q;
  assign o_srclk = srclk_q;
  assign o_rclk  = rclk_q;
  assign o_oe_n  = oe_n_q;

endmodule

// File: tb/tb_hc595_shifter.sv
// Directed bench for hc595_shifter with a behavioural '595 model
// on each instance (8x4 default and 16x1).
module tb_hc595_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d0;
  logic        en0;
  logic        rdy0, ser0, sck0, rck0, oe0;
  logic [15:0] d1;
  logic        en1;
  logic        rdy1, ser1, sck1, rck1, oe1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sr0, q0;
  logic [15:0] sr1, q1;
  logic        oe_rck0;
  int sck_n0 = 0, rck_n0 = 0, rck_hi0 = 0;
  int sck_n1 = 0, sck_hi1 = 0;
  int busy;
  int n;

  hc595_shifter #(.WIDTH(8), .CLK_DIV(4)) u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(d0), .i_enable(en0),
    .o_ready(rdy0), .o_ser(ser0),
    .o_srclk(sck0), .o_rclk(rck0),
    .o_oe_n(oe0)
  );

  hc595_shifter #(.WIDTH(16), .CLK_DIV(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(d1), .i_enable(en1),
    .o_ready(rdy1), .o_ser(ser1),
    .o_srclk(sck1), .o_rclk(rck1),
    .o_oe_n(oe1)
  );

  always #5 clk = ~clk;

  always @(posedge sck0) begin
    sr0 = {sr0[6:0], ser0};
    sck_n0++;
  end
  always @(posedge rck0) begin
    q0 = sr0;
    oe_rck0 = oe0;
    rck_n0++;
  end
  always @(posedge clk) if (rck0) rck_hi0++;

  always @(posedge sck1) begin
    sr1 = {sr1[14:0], ser1};
    sck_n1++;
  end
  always @(posedge rck1) q1 = sr1;
  always @(posedge clk) if (sck1) sck_hi1++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic run0(input logic [7:0] data,
                      input bit repulse,
                      output int nb);
    sck_n0 = 0;
    rck_n0 = 0;
    rck_hi0 = 0;
    d0 = data;
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    nb = 0;
    while (rdy0 === 1'b0 && nb < 500) begin
      nb++;
      if (repulse && (nb == 10 || nb == 72)) begin
        d0 = ~data;
        en0 = 1'b1;
      end else begin
        en0 = 1'b0;
      end
      tick();
    end
    en0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    d0 = '0;
    d1 = '0;
    tick();
    tick();
    chk("rst_outs0", {rdy0, ser0, sck0, rck0, oe0}, 5'b10001);
    chk("rst_outs1", {rdy1, ser1, sck1, rck1, oe1}, 5'b10001);
    rst_n = 1'b1;
    tick();
    chk("idle_oe0", oe0, 1'b1);

    // basic 0x55 transfer from power-up
    run0(8'h55, 1'b0, busy);
    chk("t1_busy", busy, 72);
    chk("t1_sck", sck_n0, 8);
    chk("t1_rck", rck_n0, 1);
    chk("t1_rck_hi", rck_hi0, 4);
    chk("t1_sr", sr0, 8'h55);
    chk("t1_q", q0, 8'h55);
    chk("t1_oe_at_latch", oe_rck0, 1'b1);
    chk("t1_oe_after", oe0, 1'b0);

    // AA + enable while busy (incl. last FINISH cycle) ignored
    run0(8'h55, 1'b1, busy);
    chk("t2_busy", busy, 72);
    chk("t2_q", q0, 8'h55);
    chk("t2_sck", sck_n0, 8);
    tick();
    chk("t2_no_queue", rdy0, 1'b1);
    run0(8'hAA, 1'b0, busy);
    chk("t2_next_q", q0, 8'hAA);

    // level enable: one job per IDLE visit, >=1 idle cycle
    d0 = 8'h3C;
    en0 = 1'b1;
    tick();
    chk("lvl_start", rdy0, 1'b0);
    n = 0;
    while (rdy0 === 1'b0 && n < 500) begin
      n++;
      tick();
    end
    chk("lvl_busy", n, 72);
    chk("lvl_idle", rdy0, 1'b1);
    tick();
    chk("lvl_restart", rdy0, 1'b0);
    en0 = 1'b0;
    n = 0;
    while (rdy0 === 1'b0 && n < 500) begin
      n++;
      tick();
    end
    chk("lvl_q", q0, 8'h3C);

    // reset after the 3rd SRCLK edge aborts without latch
    sck_n0 = 0;
    rck_n0 = 0;
    d0 = 8'hF0;
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    n = 0;
    while (sck_n0 < 3 && n < 500) begin
      n++;
      tick();
    end
    chk("t3_sck3", sck_n0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t3_async", {rdy0, ser0, sck0, rck0, oe0}, 5'b10001);
    tick();
    tick();
    chk("t3_no_rck", rck_n0, 0);
    chk("t3_q_kept", q0, 8'h3C);
    rst_n = 1'b1;
    tick();
    chk("t3_oe_idle", oe0, 1'b1);
    run0(8'hC3, 1'b0, busy);
    chk("t3_busy", busy, 72);
    chk("t3_q", q0, 8'hC3);
    chk("t3_oe_at_latch", oe_rck0, 1'b1);
    chk("t3_oe_after", oe0, 1'b0);

    // 16-bit, divide-by-1 instance
    sck_n1 = 0;
    sck_hi1 = 0;
    d1 = 16'h8001;
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    n = 0;
    while (rdy1 === 1'b0 && n < 500) begin
      n++;
      tick();
    end
    chk("t5_busy", n, 34);
    chk("t5_sck", sck_n1, 16);
    chk("t5_sck_hi", sck_hi1, 16);
    chk("t5_sr", sr1, 16'h8001);
    chk("t5_q", q1, 16'h8001);
    chk("t5_oe", oe1, 1'b0);

    // controller-style alternating 55/AA updates
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      w = (i % 2 == 0) ? 8'h55 : 8'hAA;
      run0(w, 1'b0, busy);
      chk("t6_busy", busy, 72);
      chk("t6_q", q0, w);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
